text_vram_sched: RTL and testbench

Scheduler for the single-port character VRAM behind the text-mode VGA path. It shares the one VRAM port between three requesters: display row prefetch, bulk screen clear, and character writes from the keyboard/CPU side. Each new character row is fetched into a line buffer during horizontal blanking. During the active region, the buffer supplies the character code for the current text column to the font stage.

---
 rtl/text_vram_sched.sv | 196 +++++++++++++++++++
 tb/tb_text_vram_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_vram_sched.sv
`default_nettype none
// ============================================================================
// Module   : text_vram_sched
// Purpose  : Shares the single-port character VRAM between the display row
//            prefetch, a bulk screen clear and single character writes. Each
//            new text row is copied into a line buffer during horizontal
//            blanking; the buffer then feeds the font stage per column.
// Revision : 1.0 - initial release
// ============================================================================
module text_vram_sched #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int CHAR_H = 16,
  parameter int ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              reset,
  // Display timing
  input  logic              i_hblank_start,
  input  logic [8:0]        i_next_vline,
  input  logic              i_next_vvalid,
  input  logic              i_disp_valid,
  input  logic [6:0]        i_disp_col,
  output logic [7:0]        o_char_code,
  output logic              o_char_valid,
  // Character write port
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [4:0]        i_wr_row,
  input  logic [6:0]        i_wr_col,
  input  logic [7:0]        i_wr_data,
  output logic              o_wr_err,
  // Screen clear
  input  logic              i_clr_req,
  output logic              o_clr_busy,
  // VRAM port
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic              o_vram_we,
  output logic [7:0]        o_vram_wdata,
  input  logic [7:0]        i_vram_rdata
);

  localparam logic [ADDR_W-1:0] c_cols_a   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(ROWS * COLS - 1);
  localparam logic [6:0]        c_cols_7   = 7'(COLS);
  localparam logic [6:0]        c_last_col = 7'(COLS - 1);
  localparam logic [4:0]        c_rows_5   = 5'(ROWS);
  localparam logic [8:0]        c_char_h   = 9'(CHAR_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [6:0]         r_fetch_cnt;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic               r_clr_busy;
  logic               r_cap_valid;
  logic [6:0]         r_cap_idx;
  logic [7:0]         r_linebuf [COLS];
  logic [7:0]         r_char_code;
  logic               r_char_valid;

  logic               w_trigger;
  logic [8:0]         w_vline_mod;
  logic [8:0]         w_fetch_row;
  logic [ADDR_W-1:0]  w_fetch_base;
  logic               w_wr_open;
  logic               w_wr_in_range;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [7:0]         w_lb_rd;

  // A fetch starts on the blanking pulse preceding the first scanline of a row.
  assign w_vline_mod  = i_next_vline % c_char_h;
  assign w_fetch_row  = i_next_vline / c_char_h;
  assign w_fetch_base = ADDR_W'(w_fetch_row) * c_cols_a;
  assign w_trigger    = i_hblank_start & i_next_vvalid & (w_vline_mod == 9'd0);

  // Writes only get the port when nothing of higher priority wants it.
  assign w_wr_open     = (r_state == S_IDLE) & ~r_clr_busy & ~w_trigger;
  assign w_wr_in_range = (i_wr_row < c_rows_5) & (i_wr_col < c_cols_7);
  assign w_wr_addr     = ADDR_W'(i_wr_row) * c_cols_a + ADDR_W'(i_wr_col);

  assign w_lb_rd = (i_disp_col < c_cols_7) ? r_linebuf[i_disp_col] : 8'h00;

  // VRAM port mux: fetch read, paused/active clear write, or a character write.
  always_comb begin
    o_vram_we    = 1'b0;
    o_vram_addr  = '0;
    o_vram_wdata = 8'h00;
    o_wr_err     = 1'b0;
    o_wr_ready   = w_wr_open;
    case (r_state)
      S_FETCH: begin
        o_vram_addr = r_base + ADDR_W'(r_fetch_cnt);
      end
      S_CLEAR: begin
        // A trigger in this cycle pauses the clear without consuming an address.
        if (!w_trigger) begin
          o_vram_we   = 1'b1;
          o_vram_addr = r_clr_addr;
        end
      end
      default: begin
        if (w_wr_open && i_wr_valid) begin
          if (w_wr_in_range) begin
            o_vram_we    = 1'b1;
            o_vram_addr  = w_wr_addr;
            o_vram_wdata = i_wr_data;
          end else begin
            o_wr_err = 1'b1;
          end
        end
      end
    endcase
  end

  // Port ownership FSM with the fetch counter and the resumable clear pointer.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_fetch_cnt <= 7'd0;
      r_clr_addr  <= '0;
      r_clr_busy  <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_idx   <= 7'd0;
    end else begin
      r_cap_valid <= (r_state == S_FETCH);
      r_cap_idx   <= r_fetch_cnt;
      if (i_clr_req && !r_clr_busy) begin
        r_clr_busy <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_base      <= w_fetch_base;
            r_fetch_cnt <= 7'd0;
            r_state     <= S_FETCH;
          end else if (r_clr_busy || i_clr_req) begin
            r_state <= S_CLEAR;
          end
        end
        S_FETCH: begin
          r_fetch_cnt <= r_fetch_cnt + 7'd1;
          if (r_fetch_cnt == c_last_col) begin
            r_state <= (r_clr_busy || i_clr_req) ? S_CLEAR : S_IDLE;
          end
        end
        S_CLEAR: begin
          if (w_trigger) begin
            r_base      <= w_fetch_base;
            r_fetch_cnt <= 7'd0;
            r_state     <= S_FETCH;
          end else if (r_clr_addr == c_clr_last) begin
            r_clr_addr <= '0;
            r_clr_busy <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read data returns one cycle after its address; store it at the delayed column.
  always_ff @(posedge pclk) begin
    if (r_cap_valid) begin
      r_linebuf[r_cap_idx] <= i_vram_rdata;
    end
  end

  // One-cycle display lookup for the font stage.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_char_code  <= 8'h00;
      r_char_valid <= 1'b0;
    end else begin
      r_char_code  <= i_disp_valid ? w_lb_rd : 8'h00;
      r_char_valid <= i_disp_valid;
    end
  end

  assign o_char_code  = r_char_code;
  assign o_char_valid = r_char_valid;
  assign o_clr_busy   = r_clr_busy;

endmodule
`default_nettype wire

// File: tb/tb_text_vram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_vram_sched
// Purpose  : Directed self-checking bench for text_vram_sched with a simple
//            synchronous VRAM model (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_vram_sched;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        hblank_start = 1'b0;
  logic [8:0]  next_vline = 9'd0;
  logic        next_vvalid = 1'b0;
  logic        disp_valid = 1'b0;
  logic [6:0]  disp_col = 7'd0;
  logic [7:0]  char_code;
  logic        char_valid;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_row = 5'd0;
  logic [6:0]  wr_col = 7'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_err;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic [11:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;

  logic [7:0]  mem [0:4095];

  int checks   = 0;
  int failures = 0;

  text_vram_sched #(.COLS(70), .ROWS(30), .CHAR_H(16), .ADDR_W(12)) dut (
    .pclk           (pclk),
    .reset          (reset),
    .i_hblank_start (hblank_start),
    .i_next_vline   (next_vline),
    .i_next_vvalid  (next_vvalid),
    .i_disp_valid   (disp_valid),
    .i_disp_col     (disp_col),
    .o_char_code    (char_code),
    .o_char_valid   (char_valid),
    .i_wr_valid     (wr_valid),
    .o_wr_ready     (wr_ready),
    .i_wr_row       (wr_row),
    .i_wr_col       (wr_col),
    .i_wr_data      (wr_data),
    .o_wr_err       (wr_err),
    .i_clr_req      (clr_req),
    .o_clr_busy     (clr_busy),
    .o_vram_addr    (vram_addr),
    .o_vram_we      (vram_we),
    .o_vram_wdata   (vram_wdata),
    .i_vram_rdata   (vram_rdata)
  );

  always #5 pclk = ~pclk;

  // Single-port synchronous VRAM
  always @(posedge pclk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no checking inside)
  task automatic show_col(input logic [6:0] c, output logic [7:0] code, output logic v);
    @(negedge pclk);
    disp_valid = 1'b1;
    disp_col   = c;
    @(negedge pclk);
    code       = char_code;
    v          = char_valid;
    disp_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [8:0] vline);
    @(negedge pclk);
    hblank_start = 1'b1;
    next_vline   = vline;
    next_vvalid  = 1'b1;
    @(negedge pclk);
    hblank_start = 1'b0;
    next_vvalid  = 1'b0;
    repeat (72) @(negedge pclk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    @(negedge pclk);
    checks++; if (char_code !== 8'h00) begin failures++; $display("FAIL reset_char_code got=%0h exp=0", char_code); end
    checks++; if (char_valid !== 1'b0) begin failures++; $display("FAIL reset_char_valid got=%0b exp=0", char_valid); end
    checks++; if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got=%0b exp=0", clr_busy); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%0b exp=0", wr_err); end
    checks++; if (vram_we !== 1'b0 || vram_addr !== 12'd0 || vram_wdata !== 8'h00) begin
      failures++; $display("FAIL reset_bus got we=%0b addr=%0d wdata=%0h exp 0/0/0", vram_we, vram_addr, vram_wdata);
    end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
  endtask

  task automatic test_write_handshake;
    @(negedge pclk);
    wr_valid = 1'b1; wr_row = 5'd3; wr_col = 7'd5; wr_data = 8'h5A;
    #1;
    checks++; if (vram_we !== 1'b1 || vram_addr !== 12'd215 || vram_wdata !== 8'h5A) begin
      failures++; $display("FAIL write_bus got we=%0b addr=%0d wdata=%0h exp 1/215/5a", vram_we, vram_addr, vram_wdata);
    end
    checks++; if (wr_ready !== 1'b1 || wr_err !== 1'b0) begin
      failures++; $display("FAIL write_ready_err got ready=%0b err=%0b exp 1/0", wr_ready, wr_err);
    end
    @(negedge pclk);
    wr_row = 5'd30; wr_col = 7'd0; wr_data = 8'hEE;
    #1;
    checks++; if (mem[215] !== 8'h5A) begin failures++; $display("FAIL write_mem215 got=%0h exp=5a", mem[215]); end
    checks++; if (vram_we !== 1'b0 || wr_err !== 1'b1 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL write_bad_row got we=%0b err=%0b ready=%0b exp 0/1/1", vram_we, wr_err, wr_ready);
    end
    @(negedge pclk);
    wr_row = 5'd0; wr_col = 7'd70;
    #1;
    checks++; if (vram_we !== 1'b0 || wr_err !== 1'b1) begin
      failures++; $display("FAIL write_bad_col got we=%0b err=%0b exp 0/1", vram_we, wr_err);
    end
    @(negedge pclk);
    wr_valid = 1'b0;
    #1;
    checks++; if (wr_err !== 1'b0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL write_err_pulse got err=%0b we=%0b exp 0/0", wr_err, vram_we);
    end
  endtask

  task automatic test_row_fetch;
    logic [7:0] exp_code;
    // Preload row 2 with 0x41+i through the write port
    for (int i = 0; i < 70; i++) begin
      @(negedge pclk);
      wr_valid = 1'b1; wr_row = 5'd2; wr_col = 7'(i); wr_data = 8'(8'h41 + i);
    end
    @(negedge pclk);
    wr_valid = 1'b0;
    checks++; if (mem[140] !== 8'h41 || mem[209] !== 8'h86) begin
      failures++; $display("FAIL preload_mem got m140=%0h m209=%0h exp 41/86", mem[140], mem[209]);
    end
    // Trigger on cycle T
    @(negedge pclk);
    hblank_start = 1'b1; next_vline = 9'd32; next_vvalid = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL fetch_T got ready=%0b we=%0b exp 0/0", wr_ready, vram_we);
    end
    @(negedge pclk);
    hblank_start = 1'b0; next_vvalid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i > 0) @(negedge pclk);
      checks++; if (vram_addr !== 12'(140 + i) || vram_we !== 1'b0 || wr_ready !== 1'b0) begin
        failures++; $display("FAIL fetch_addr i=%0d got addr=%0d we=%0b ready=%0b exp %0d/0/0", i, vram_addr, vram_we, wr_ready, 140 + i);
      end
    end
    @(negedge pclk);
    checks++; if (wr_ready !== 1'b1 || vram_addr !== 12'd0) begin
      failures++; $display("FAIL fetch_end got ready=%0b addr=%0d exp 1/0", wr_ready, vram_addr);
    end
    // Column sweep, one cycle latency
    for (int i = 0; i <= 70; i++) begin
      @(negedge pclk);
      if (i > 0) begin
        exp_code = 8'(8'h41 + i - 1);
        checks++; if (char_valid !== 1'b1 || char_code !== exp_code) begin
          failures++; $display("FAIL disp_col col=%0d got v=%0b code=%0h exp 1/%0h", i - 1, char_valid, char_code, exp_code);
        end
      end
      if (i < 70) begin disp_valid = 1'b1; disp_col = 7'(i); end
      else disp_valid = 1'b0;
    end
    @(negedge pclk);
    checks++; if (char_valid !== 1'b0 || char_code !== 8'h00) begin
      failures++; $display("FAIL disp_idle got v=%0b code=%0h exp 0/0", char_valid, char_code);
    end
  endtask

  task automatic test_no_backwrite;
    logic [7:0] code;
    logic       v;
    @(negedge pclk);
    wr_valid = 1'b1; wr_row = 5'd2; wr_col = 7'd0; wr_data = 8'h99;
    @(negedge pclk);
    wr_valid = 1'b0;
    show_col(7'd0, code, v);
    checks++; if (code !== 8'h41 || v !== 1'b1) begin
      failures++; $display("FAIL no_backwrite got code=%0h v=%0b exp 41/1", code, v);
    end
    do_fetch(9'd32);
    show_col(7'd0, code, v);
    checks++; if (code !== 8'h99) begin failures++; $display("FAIL refetch_col0 got=%0h exp=99", code); end
    show_col(7'd69, code, v);
    checks++; if (code !== 8'h86) begin failures++; $display("FAIL refetch_col69 got=%0h exp=86", code); end
  endtask

  task automatic test_nonfetch;
    int bad;
    for (int k = 0; k < 2; k++) begin
      bad = 0;
      @(negedge pclk);
      hblank_start = 1'b1;
      next_vline   = (k == 0) ? 9'd33 : 9'd32;
      next_vvalid  = (k == 0) ? 1'b1 : 1'b0;
      #1;
      if (wr_ready !== 1'b1) bad++;
      @(negedge pclk);
      hblank_start = 1'b0; next_vvalid = 1'b0;
      for (int i = 0; i < 72; i++) begin
        if (vram_addr !== 12'd0 || vram_we !== 1'b0 || wr_ready !== 1'b1) bad++;
        @(negedge pclk);
      end
      checks++; if (bad != 0) begin
        failures++; $display("FAIL nonfetch case=%0d got bad_cycles=%0d exp 0", k, bad);
      end
    end
  endtask

  task automatic test_contention;
    @(negedge pclk);
    hblank_start = 1'b1; next_vline = 9'd0; next_vvalid = 1'b1;
    wr_valid = 1'b1; wr_row = 5'd1; wr_col = 7'd2; wr_data = 8'h77;
    #1;
    checks++; if (wr_ready !== 1'b0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL contend_T got ready=%0b we=%0b exp 0/0", wr_ready, vram_we);
    end
    @(negedge pclk);
    hblank_start = 1'b0; next_vvalid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i > 0) @(negedge pclk);
      checks++; if (wr_ready !== 1'b0 || vram_we !== 1'b0 || vram_addr !== 12'(i)) begin
        failures++; $display("FAIL contend_stall i=%0d got ready=%0b we=%0b addr=%0d exp 0/0/%0d", i, wr_ready, vram_we, vram_addr, i);
      end
    end
    @(negedge pclk);
    checks++; if (wr_ready !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 12'd72 || vram_wdata !== 8'h77) begin
      failures++; $display("FAIL contend_accept got ready=%0b we=%0b addr=%0d wdata=%0h exp 1/1/72/77", wr_ready, vram_we, vram_addr, vram_wdata);
    end
    @(negedge pclk);
    wr_valid = 1'b0;
    checks++; if (mem[72] !== 8'h77) begin failures++; $display("FAIL contend_mem got=%0h exp=77", mem[72]); end
  endtask

  task automatic test_clear;
    @(negedge pclk);
    clr_req = 1'b1;
    @(negedge pclk);
    clr_req = 1'b0;
    checks++; if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL clr_start got busy=%0b ready=%0b exp 1/0", clr_busy, wr_ready);
    end
    for (int w = 0; w < 1000; w++) begin
      if (w > 0) @(negedge pclk);
      checks++; if (vram_we !== 1'b1 || vram_addr !== 12'(w) || vram_wdata !== 8'h00) begin
        failures++; $display("FAIL clr_write a=%0d got we=%0b addr=%0d wdata=%0h", w, vram_we, vram_addr, vram_wdata);
      end
    end
    // Trigger while the clear pointer sits at 1000
    @(negedge pclk);
    hblank_start = 1'b1; next_vline = 9'd64; next_vvalid = 1'b1;
    #1;
    checks++; if (vram_we !== 1'b0 || clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL clr_pause got we=%0b busy=%0b ready=%0b exp 0/1/0", vram_we, clr_busy, wr_ready);
    end
    @(negedge pclk);
    hblank_start = 1'b0; next_vvalid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (i > 0) @(negedge pclk);
      checks++; if (vram_we !== 1'b0 || vram_addr !== 12'(280 + i) || clr_busy !== 1'b1) begin
        failures++; $display("FAIL clr_fetch i=%0d got we=%0b addr=%0d busy=%0b exp 0/%0d/1", i, vram_we, vram_addr, clr_busy, 280 + i);
      end
    end
    for (int w = 1000; w < 2100; w++) begin
      @(negedge pclk);
      checks++; if (vram_we !== 1'b1 || vram_addr !== 12'(w) || clr_busy !== 1'b1) begin
        failures++; $display("FAIL clr_resume a=%0d got we=%0b addr=%0d busy=%0b", w, vram_we, vram_addr, clr_busy);
      end
      // A second request while busy must not restart the clear
      clr_req = (w == 1500);
    end
    @(negedge pclk);
    checks++; if (clr_busy !== 1'b0 || vram_we !== 1'b0 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL clr_done got busy=%0b we=%0b ready=%0b exp 0/0/1", clr_busy, vram_we, wr_ready);
    end
    checks++; if (mem[140] !== 8'h00 || mem[215] !== 8'h00 || mem[72] !== 8'h00) begin
      failures++; $display("FAIL clr_mem got m140=%0h m215=%0h m72=%0h exp 0/0/0", mem[140], mem[215], mem[72]);
    end
  endtask

  task automatic test_reset_mid_clear;
    @(negedge pclk);
    clr_req = 1'b1;
    @(negedge pclk);
    clr_req = 1'b0;
    repeat (500) @(negedge pclk);
    checks++; if (vram_addr !== 12'd500 || vram_we !== 1'b1) begin
      failures++; $display("FAIL rst_clr_pos got addr=%0d we=%0b exp 500/1", vram_addr, vram_we);
    end
    reset = 1'b1;
    @(negedge pclk);
    checks++; if (clr_busy !== 1'b0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL rst_clr_abort got busy=%0b we=%0b exp 0/0", clr_busy, vram_we);
    end
    reset = 1'b0;
    @(negedge pclk);
    checks++; if (wr_ready !== 1'b1 || vram_addr !== 12'd0 || vram_we !== 1'b0) begin
      failures++; $display("FAIL rst_clr_idle got ready=%0b addr=%0d we=%0b exp 1/0/0", wr_ready, vram_addr, vram_we);
    end
    clr_req = 1'b1;
    @(negedge pclk);
    clr_req = 1'b0;
    checks++; if (vram_we !== 1'b1 || vram_addr !== 12'd0) begin
      failures++; $display("FAIL rst_clr_restart got we=%0b addr=%0d exp 1/0", vram_we, vram_addr);
    end
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    test_reset();
    test_write_handshake();
    test_row_fetch();
    test_no_backwrite();
    test_nonfetch();
    test_contention();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
